dnn_accel_onchip_mem_dp: RTL
============================

DNN_ACCEL_ONCHIP_MEM_DP -- requirements
Module: dnn_accel_onchip_mem_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter DEPTH, default 800: number of words.
REQ-003 SHALL have parameter ADDR_W, default 10: address width, with 2^ADDR_W >= DEPTH.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports sN_address (input, ADDR_W), sN_chipselect (input, 1), sN_read (input, 1), sN_write (input, 1), sN_byteenable (input, DATA_W/8) and sN_writedata (input, DATA_W), for N = 1 and 2.
REQ-008 SHALL have outputs sN_readdata (DATA_W), sN_readdatavalid (1) and sN_waitrequest (1), for N = 1 and 2.
REQ-009 SHALL have port clear_req, input, 1 bit: a one-cycle pulse requests a zero-fill of the memory.
REQ-010 SHALL have port clear_busy, output, 1 bit: high while the zero-fill sweep runs.

Function
REQ-011 An access on port N SHALL be accepted when sN_chipselect=1, (sN_read or sN_write)=1 and sN_waitrequest=0.
REQ-012 An accepted write SHALL update only the bytes whose sN_byteenable bit is 1, at the next rising edge.
REQ-013 If read and write are asserted together, the write SHALL take effect and no read SHALL be issued.
REQ-014 An accepted read SHALL assert sN_readdatavalid for exactly one cycle, exactly RD_LAT cycles after acceptance, with sN_readdata valid in that cycle.
REQ-015 Reads SHALL be fully pipelined: one read per port per cycle, returned in order.
REQ-016 Outside readdatavalid cycles, sN_readdata SHALL hold its last value.
REQ-017 Read-during-write to the same address, on the same port or across ports, SHALL return the old data.
REQ-018 When s1 and s2 both write the same address in one cycle, s1 SHALL win the bytes it enables; s2 SHALL win only the bytes s1 does not enable.
REQ-019 An address >= DEPTH on a write SHALL be dropped and leave memory unchanged.
REQ-020 An address >= DEPTH on a read SHALL return all-zero data, with normal readdatavalid timing.
REQ-021 The FSM SHALL have two states, IDLE and CLEAR.
REQ-022 In IDLE, clear_req=1 SHALL move the FSM to CLEAR and load the sweep counter with 0.
REQ-023 On the same cycle as REQ-022, any port accesses SHALL still be accepted.
REQ-024 In CLEAR, the block SHALL write all-zero data to the word at the sweep counter once per cycle and then increment the counter.
REQ-025 After the cycle that writes DEPTH-1, the FSM SHALL return to IDLE, so a sweep lasts exactly DEPTH cycles.
REQ-026 clear_busy SHALL be 1 exactly in CLEAR cycles.
REQ-027 sN_waitrequest SHALL be 1 exactly in CLEAR cycles.
REQ-028 Reads accepted before entering CLEAR SHALL complete normally.
REQ-029 clear_req SHALL be ignored while in CLEAR.

Reset
REQ-030 While reset_n=0, asynchronously: FSM=IDLE, sweep counter=0, read pipeline flushed.
REQ-031 While reset_n=0, all outputs SHALL be 0 (readdata, readdatavalid, waitrequest, clear_busy).
REQ-032 Reset SHALL NOT alter memory contents.
REQ-033 Reset during CLEAR SHALL abort the sweep, leaving words 0..k-1 zeroed and the rest unchanged.
REQ-034 After reset_n rises, the first accesses SHALL be accepted at the next rising edge.

Verification
REQ-035 Byte write: s1 writes 0xAABBCCDD to addr 5 with byteenable 0xF, then 0x11223344 with byteenable 0x3; a read of addr 5 SHALL return 0xAABB3344 after RD_LAT cycles, for both RD_LAT=1 and RD_LAT=2.
REQ-036 Collision: s1 writes 0x000000FF (byteenable 0x1) and s2 writes 0x12345678 (byteenable 0xF) to addr 7 in one cycle; addr 7 SHALL then read 0x123456FF.
REQ-037 Read-during-write: addr 9 holds 0x1; s1 writes 0x2 to addr 9 while s2 reads addr 9; s2 SHALL return 0x1, and the next s2 read of addr 9 SHALL return 0x2.
REQ-038 Bounds: a write to addr 800 (DEPTH=800) SHALL be dropped; a read of addr 1023 SHALL return 0x0 with readdatavalid.
REQ-039 Clear: a clear_req pulse SHALL hold clear_busy and both waitrequests high for exactly 800 cycles, and afterwards every address SHALL read 0; a second clear_req mid-sweep SHALL NOT extend the sweep.
REQ-040 Reset mid-clear: reset_n low at sweep cycle 100 SHALL leave addr 0..99 zero and addr 100..799 holding their prior values, with all outputs 0 during reset.

Source files
------------

// File: rtl/dnn_accel_onchip_mem_dp.sv
// Dual-port on-chip word memory for the DNN accelerator: two symmetric access ports
// with byte enables, pipelined reads (RD_LAT 1 or 2) and a zero-fill sweep engine.

module dnn_accel_onchip_mem_dp_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_acc,
    input  logic [DATA_W-1:0] rd_word,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);
    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DATA_W-1:0] data_pipe;

    // Stages only load when their input is valid, so the last stage holds its
    // value between returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc)
                data_pipe[1] <= rd_word;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1])
                    data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign readdata      = data_pipe[RD_LAT];
    assign readdatavalid = vld_pipe[RD_LAT];
endmodule

module dnn_accel_onchip_mem_dp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 800,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    input  logic                clear_req,
    output logic                clear_busy
);
    localparam int                NUM_PORTS = 2;
    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              cs;
        logic              rd;
        logic              wr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t                             state;
    logic [ADDR_W-1:0]                  sweep_cnt;
    logic                               busy;
    req_t [NUM_PORTS-1:0]               req;
    logic [NUM_PORTS-1:0]               in_range;
    logic [NUM_PORTS-1:0]               wr_acc;
    logic [NUM_PORTS-1:0]               rd_acc;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rd_word;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata;
    logic [NUM_PORTS-1:0]               rvalid;

    assign req[0] = '{addr: s1_address, cs: s1_chipselect, rd: s1_read, wr: s1_write,
                      be: s1_byteenable, wdata: s1_writedata};
    assign req[1] = '{addr: s2_address, cs: s2_chipselect, rd: s2_read, wr: s2_write,
                      be: s2_byteenable, wdata: s2_writedata};

    assign busy = (state == CLEAR);

    // A simultaneous read+write is treated as a write only.
    always_comb begin
        in_range = '0;
        wr_acc   = '0;
        rd_acc   = '0;
        rd_word  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_range[p] = ({1'b0, req[p].addr} < DEPTH_L);
            wr_acc[p]   = req[p].cs & req[p].wr & ~busy;
            rd_acc[p]   = req[p].cs & req[p].rd & ~req[p].wr & ~busy;
            rd_word[p]  = in_range[p] ? mem[req[p].addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                    end
                end
                CLEAR: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST_ADDR)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset. Port 2 is applied before port 1 so that port 1's
    // enabled bytes take precedence on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (busy) begin
                mem[sweep_cnt] <= '0;
            end else begin
                for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                    if (wr_acc[p] && in_range[p]) begin
                        for (int b = 0; b < BE_W; b++) begin
                            if (req[p].be[b])
                                mem[req[p].addr][8*b +: 8] <= req[p].wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_port
            dnn_accel_onchip_mem_dp_rd_pipe #(
                .DATA_W (DATA_W),
                .RD_LAT (RD_LAT)
            ) u_rd_pipe (
                .clk           (clk),
                .reset_n       (reset_n),
                .rd_acc        (rd_acc[g]),
                .rd_word       (rd_word[g]),
                .readdata      (rdata[g]),
                .readdatavalid (rvalid[g])
            );
        end
    endgenerate

    assign s1_readdata      = rdata[0];
    assign s1_readdatavalid = rvalid[0];
    assign s2_readdata      = rdata[1];
    assign s2_readdatavalid = rvalid[1];
    assign s1_waitrequest   = busy;
    assign s2_waitrequest   = busy;
    assign clear_busy       = busy;
endmodule
